// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, PC, IR, MAR, MDR, Y, HI, LO,
// 64-bit Z and a combinational ALU, all sharing one bus. Control strobes come
// from an external sequencer; memory read data arrives on Mdatain.
module data_path (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCout,
    input  logic        ZHighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  ROR,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        Cin,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] MARq,
    output logic [31:0] IRq,
    output logic [63:0] Zq
);

    // ALU operation codes
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;

    // A strobe only counts when it is a clean 1; X/Z from an undriven
    // sequencer output must behave exactly like 0.
    function automatic logic on(input logic s);
        return (s === 1'b1);
    endfunction

    logic [31:0] pc, ir, mar, mdr, y, hi, lo;
    logic [63:0] z;
    logic [31:0] rf [1:15];
    logic [15:1] rin;
    logic [63:0] alu_c;

    assign rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in};

    assign MARq = mar;
    assign IRq  = ir;
    assign Zq   = z;

    // Bus source priority mux; nothing selected drives 0
    always_comb begin
        BusMuxOut = 32'd0;
        if      (on(PCout))    BusMuxOut = pc;
        else if (on(ZHighout)) BusMuxOut = z[63:32];
        else if (on(Zlowout))  BusMuxOut = z[31:0];
        else if (on(MDRout))   BusMuxOut = mdr;
        else if (on(R2out))    BusMuxOut = rf[2];
        else if (on(R3out))    BusMuxOut = rf[3];
        else if (on(R4out))    BusMuxOut = rf[4];
        else if (on(R5out))    BusMuxOut = rf[5];
        else if (on(R6out))    BusMuxOut = rf[6];
        else if (on(R7out))    BusMuxOut = rf[7];
    end

    // General registers R1..R15; R0 is hardwired to zero and has no storage
    for (genvar i = 1; i <= 15; i++) begin : g_rf
        // Load Ri from the bus on its strobe
        always_ff @(posedge Clock) begin
            if (Clear)
                rf[i] <= 32'd0;
            else if (on(rin[i]))
                rf[i] <= BusMuxOut;
        end
    end

    // PC: increment wins over a bus load
    always_ff @(posedge Clock) begin
        if (Clear)
            pc <= 32'd0;
        else if (on(IncPC))
            pc <= pc + 32'd1;
        else if (on(PCin))
            pc <= BusMuxOut;
    end

    // MDR takes memory data on a read cycle, otherwise the bus
    always_ff @(posedge Clock) begin
        if (Clear)
            mdr <= 32'd0;
        else if (on(MDRin))
            mdr <= on(Read) ? Mdatain : BusMuxOut;
    end

    // Plain bus-loaded registers: MAR, IR, Y, HI, LO
    always_ff @(posedge Clock) begin
        if (Clear) begin
            mar <= 32'd0;
            ir  <= 32'd0;
            y   <= 32'd0;
            hi  <= 32'd0;
            lo  <= 32'd0;
        end else begin
            if (on(MARin)) mar <= BusMuxOut;
            if (on(IRin))  ir  <= BusMuxOut;
            if (on(Yin))   y   <= BusMuxOut;
            if (on(HIin))  hi  <= BusMuxOut;
            if (on(LOin))  lo  <= BusMuxOut;
        end
    end

    // Z halves load independently from the ALU result
    always_ff @(posedge Clock) begin
        if (Clear) begin
            z <= 64'd0;
        end else begin
            if (on(ZLowIn))  z[31:0]  <= alu_c[31:0];
            if (on(ZHighIn)) z[63:32] <= alu_c[63:32];
        end
    end

    // ALU: A = Y, B = bus. Rotates go through a doubled word so that an
    // amount of 0 falls out naturally as A.
    logic [31:0] a, b;
    logic [4:0]  amt;
    logic [32:0] sum;
    logic [63:0] dbl, rol_w, ror_w, prod;
    logic signed [31:0] quo, rem;

    assign a   = y;
    assign b   = BusMuxOut;
    assign amt = b[4:0];

    // Combinational ALU result; unknown or unused op codes yield 0
    always_comb begin
        alu_c = 64'd0;
        sum   = {1'b0, a} + {1'b0, b} + {32'd0, on(Cin)};
        dbl   = {a, a};
        rol_w = dbl << amt;
        ror_w = dbl >> amt;
        prod  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        quo   = 32'sd0;
        rem   = 32'sd0;
        if (b != 32'd0) begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
        case (ROR)
            OP_ADD:  alu_c = {31'd0, sum};
            OP_SUB:  alu_c = {32'd0, a - b};
            OP_AND:  alu_c = {32'd0, a & b};
            OP_OR:   alu_c = {32'd0, a | b};
            OP_SHR:  alu_c = {32'd0, a >> amt};
            OP_SHRA: alu_c = {32'd0, $unsigned($signed(a) >>> amt)};
            OP_SHL:  alu_c = {32'd0, a << amt};
            OP_ROL:  alu_c = {32'd0, rol_w[63:32]};
            OP_ROR:  alu_c = {32'd0, ror_w[31:0]};
            OP_MUL:  alu_c = prod;
            OP_DIV:  alu_c = (b == 32'd0) ? 64'd0 : {rem, quo};
            OP_NEG:  alu_c = {32'd0, 32'd0 - b};
            OP_NOT:  alu_c = {32'd0, ~b};
            default: alu_c = 64'd0;
        endcase
    end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: each task drives strobe sequences, pushes
// the expected observation, and pops/compares once the DUT shows it.
module tb_data_path;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        PCout = 0, ZHighout = 0, Zlowout = 0, MDRout = 0;
    logic        R2out = 0, R3out = 0, R4out = 0, R5out = 0, R6out = 0, R7out = 0;
    logic        MARin = 0, PCin = 0, MDRin = 0, IRin = 0, Yin = 0, IncPC = 0, Read = 0;
    logic [4:0]  ROR = 5'd0;
    logic        R1in = 0, R2in = 0, R3in = 0, R4in = 0, R5in = 0, R6in = 0, R7in = 0, R8in = 0;
    logic        R9in = 0, R10in = 0, R11in = 0, R12in = 0, R13in = 0, R14in = 0, R15in = 0;
    logic        HIin = 0, LOin = 0, ZHighIn = 0, ZLowIn = 0, Cin = 0;
    logic [31:0] Mdatain = 32'd0;
    logic [31:0] BusMuxOut, MARq, IRq;
    logic [63:0] Zq;

    logic [63:0] exp_q [$];
    logic [63:0] e;
    int tests = 0;
    int fails = 0;

    data_path dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .ROR(ROR),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
        .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in),
        .R11in(R11in), .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
        .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .MARq(MARq), .IRq(IRq), .Zq(Zq)
    );

    always #5 Clock = ~Clock;

    // ALU vectors: Y, B, op, Cin, expected Z (both halves loaded)
    localparam int N_ALU = 18;
    localparam logic [31:0] T_Y [N_ALU] = '{
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000007, 32'h00000005, 32'hF0F0F0F0,
        32'hF0F0F0F0, 32'h80000010, 32'h80000010, 32'h80000010, 32'h80000001, 32'h80000001,
        32'h80000001, 32'h00000000, 32'h00000000, 32'h00000007, 32'h00000005, 32'h00010000};
    localparam logic [31:0] T_B [N_ALU] = '{
        32'h00000001, 32'h00000001, 32'h00000003, 32'h00000002, 32'h00000007, 32'h0FF00FF0,
        32'h0FF00FF0, 32'h00000004, 32'h00000004, 32'h00000004, 32'h00000001, 32'h00000020,
        32'h00000001, 32'h00000001, 32'h0000FFFF, 32'h00000000, 32'h00000007, 32'h00010000};
    localparam logic [4:0] T_OP [N_ALU] = '{
        5'd0, 5'd0, 5'd9, 5'd10, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
        5'd6, 5'd7, 5'd7, 5'd8, 5'd11, 5'd12, 5'd10, 5'd13, 5'd9};
    localparam logic T_C [N_ALU] = '{
        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [63:0] T_EX [N_ALU] = '{
        64'h00000001_00000000, 64'h00000001_00000001, 64'hFFFFFFFF_FFFFFFFA,
        64'h00000001_00000003, 64'h00000000_FFFFFFFE, 64'h00000000_00F000F0,
        64'h00000000_FFF0FFF0, 64'h00000000_08000001, 64'h00000000_F8000001,
        64'h00000000_00000100, 64'h00000000_00000003, 64'h00000000_80000001,
        64'h00000000_C0000000, 64'h00000000_FFFFFFFF, 64'h00000000_FFFF0000,
        64'h00000000_00000000, 64'h00000000_00000000, 64'h00000001_00000000};

    task automatic idle();
        PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0;
        R2out = 0; R3out = 0; R4out = 0; R5out = 0; R6out = 0; R7out = 0;
        MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
        ROR = 5'd0; Cin = 0; Clear = 0;
        R1in = 0; R2in = 0; R3in = 0; R4in = 0; R5in = 0; R6in = 0; R7in = 0; R8in = 0;
        R9in = 0; R10in = 0; R11in = 0; R12in = 0; R13in = 0; R14in = 0; R15in = 0;
        HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0;
    endtask

    // One rising edge with the current strobes, then release them
    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    task automatic test_reset();
        Clear = 1; PCin = 1; MDRout = 1;
        tick();
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL reset_bus got %h want %h", BusMuxOut, e); end
        e = exp_q.pop_front(); tests++;
        if ({32'd0, MARq} !== e) begin fails++; $display("FAIL reset_mar got %h want %h", MARq, e); end
        e = exp_q.pop_front(); tests++;
        if ({32'd0, IRq} !== e) begin fails++; $display("FAIL reset_ir got %h want %h", IRq, e); end
        e = exp_q.pop_front(); tests++;
        if (Zq !== e) begin fails++; $display("FAIL reset_z got %h want %h", Zq, e); end
    endtask

    task automatic test_load();
        mem_to_mdr(32'h12); MDRout = 1; R2in = 1; tick();
        mem_to_mdr(32'h14); MDRout = 1; R3in = 1; tick();
        mem_to_mdr(32'h18); MDRout = 1; R1in = 1; tick();
        exp_q.push_back(64'h12);
        R2out = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL load_r2 got %h want %h", BusMuxOut, e); end
        idle();
        exp_q.push_back(64'h14);
        R3out = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL load_r3 got %h want %h", BusMuxOut, e); end
        idle();
    endtask

    task automatic test_ror();
        R2out = 1; Yin = 1; tick();
        R3out = 1; ROR = 5'b01000; ZLowIn = 1;
        exp_q.push_back(64'h00000000_00012000);
        tick();
        e = exp_q.pop_front(); tests++;
        if (Zq !== e) begin fails++; $display("FAIL ror_z got %h want %h", Zq, e); end
        exp_q.push_back(64'h00012000);
        Zlowout = 1; R1in = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL ror_bus got %h want %h", BusMuxOut, e); end
        tick();
    endtask

    task automatic test_alu();
        for (int i = 0; i < N_ALU; i++) begin
            mem_to_mdr(T_Y[i]); MDRout = 1; Yin = 1; tick();
            mem_to_mdr(T_B[i]);
            MDRout = 1; ROR = T_OP[i]; Cin = T_C[i]; ZLowIn = 1; ZHighIn = 1;
            exp_q.push_back(T_EX[i]);
            tick();
            e = exp_q.pop_front(); tests++;
            if (Zq !== e) begin fails++; $display("FAIL alu[%0d] op=%b got %h want %h", i, T_OP[i], Zq, e); end
        end
        // Low-half-only load leaves Z[63:32] from the previous MUL intact
        mem_to_mdr(32'd1);
        MDRout = 1; ROR = 5'd0; ZLowIn = 1;
        exp_q.push_back(64'h00000001_00010001);
        tick();
        e = exp_q.pop_front(); tests++;
        if (Zq !== e) begin fails++; $display("FAIL alu_zlow_only got %h want %h", Zq, e); end
        exp_q.push_back(64'h00000001);
        ZHighout = 1; Zlowout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL bus_zhigh_prio got %h want %h", BusMuxOut, e); end
        idle();
    endtask

    task automatic test_pc();
        mem_to_mdr(32'd5); MDRout = 1; PCin = 1; tick();
        PCout = 1; MARin = 1; IncPC = 1; tick();
        exp_q.push_back(64'd5);
        e = exp_q.pop_front(); tests++;
        if ({32'd0, MARq} !== e) begin fails++; $display("FAIL pc_mar got %h want %h", MARq, e); end
        exp_q.push_back(64'd6);
        PCout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL pc_inc got %h want %h", BusMuxOut, e); end
        idle();
        // IncPC beats PCin (MDR still holds 5)
        MDRout = 1; PCin = 1; IncPC = 1; tick();
        exp_q.push_back(64'd7);
        PCout = 1; MDRout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL pc_prio got %h want %h", BusMuxOut, e); end
        idle();
        mem_to_mdr(32'h28918000); MDRout = 1; IRin = 1; tick();
        exp_q.push_back(64'h28918000);
        e = exp_q.pop_front(); tests++;
        if ({32'd0, IRq} !== e) begin fails++; $display("FAIL ir_load got %h want %h", IRq, e); end
        // PC wraps at 2^32
        mem_to_mdr(32'hFFFFFFFF); MDRout = 1; PCin = 1; tick();
        IncPC = 1; tick();
        exp_q.push_back(64'd0);
        PCout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL pc_wrap got %h want %h", BusMuxOut, e); end
        idle();
    endtask

    task automatic test_back_to_back();
        mem_to_mdr(32'hA5A50001);
        MDRout = 1; R4in = 1; R5in = 1; tick();
        // R4 loaded at the previous edge drives the bus right away
        R4out = 1; R6in = 1; tick();
        exp_q.push_back(64'hA5A50001);
        R5out = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL multi_in_r5 got %h want %h", BusMuxOut, e); end
        idle();
        exp_q.push_back(64'hA5A50001);
        R6out = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL b2b_r6 got %h want %h", BusMuxOut, e); end
        idle();
        // MDRin without Read takes the bus (R7 is 0), ignoring Mdatain
        Mdatain = 32'hDEADBEEF; R7out = 1; MDRin = 1; tick();
        exp_q.push_back(64'd0);
        MDRout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL mdr_from_bus got %h want %h", BusMuxOut, e); end
        idle();
    endtask

    task automatic test_clear();
        mem_to_mdr(32'h0BADF00D);
        MDRout = 1; R1in = 1; R2in = 1; MARin = 1; IRin = 1; PCin = 1; Clear = 1;
        tick();
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL clear_bus_idle got %h want %h", BusMuxOut, e); end
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); tests++;
        if ({32'd0, MARq} !== e || {32'd0, IRq} !== e || Zq !== e) begin
            fails++; $display("FAIL clear_regs got mar=%h ir=%h z=%h want %h", MARq, IRq, Zq, e);
        end
        exp_q.push_back(64'd0);
        R2out = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL clear_r2 got %h want %h", BusMuxOut, e); end
        idle();
        exp_q.push_back(64'd0);
        PCout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL clear_pc got %h want %h", BusMuxOut, e); end
        idle();
        exp_q.push_back(64'd0);
        MDRout = 1; #1;
        e = exp_q.pop_front(); tests++;
        if ({32'd0, BusMuxOut} !== e) begin fails++; $display("FAIL clear_mdr got %h want %h", BusMuxOut, e); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load();
        test_ror();
        test_alu();
        test_pc();
        test_back_to_back();
        test_clear();
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
